// File: rtl/vrf_write_arbiter_pkg.sv
// Shared types and sizing for the vector register file write path.
package vrf_pkg;

  localparam int unsigned VRF_DEPTH = 16;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned ADDR_W    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vrf_wr_t;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/vrf_write_arbiter_if.sv
// Writeback requester, reservation and register-file write-port bundle.
interface vrf_write_arbiter_if #(
  parameter int unsigned DATA_W = vrf_pkg::DATA_W,
  parameter int unsigned ADDR_W = vrf_pkg::ADDR_W,
  parameter int unsigned DEPTH  = vrf_pkg::VRF_DEPTH
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;

  logic [DEPTH-1:0]  busy;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              err_unrsv;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output rsv_valid, rsv_addr,
    input  alu_ready, mem_ready, busy, we3, wa3, wd3, err_unrsv
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  rsv_valid, rsv_addr,
    output alu_ready, mem_ready, busy, we3, wa3, wd3, err_unrsv
  );

endinterface

// File: rtl/vrf_write_arbiter_rr.sv
// Two-way round-robin arbiter; pointer only moves on contended grants.
module rr_arbiter2
  import vrf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PRI_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (ptr_q == PRI_ALU) begin
          gnt   = 2'b01;
          ptr_d = PRI_MEM;
        end else begin
          gnt   = 2'b10;
          ptr_d = PRI_ALU;
        end
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single VRF write port
// and tracks per-register pending writes.
module vrf_write_arbiter
  import vrf_pkg::*;
#(
  parameter int unsigned DATA_W = vrf_pkg::DATA_W,
  parameter int unsigned ADDR_W = vrf_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vrf_write_arbiter_if.slave   bus
);

  vrf_wr_t              alu_buf_q, alu_buf_d;
  vrf_wr_t              mem_buf_q, mem_buf_d;
  logic                 alu_full_q, alu_full_d;
  logic                 mem_full_q, mem_full_d;
  logic [1:0]           gnt;
  logic                 alu_acc, mem_acc;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [VRF_DEPTH-1:0] busy_q, busy_d;
  logic                 we3_q, we3_d;
  logic [ADDR_W-1:0]    wa3_q, wa3_d;
  logic [DATA_W-1:0]    wd3_q, wd3_d;
  logic                 err_q, err_d;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({mem_full_q, alu_full_q}),
    .gnt   (gnt)
  );

  // Ready is gated by rst_n so it is low throughout reset; a granted buffer
  // may be refilled in the same cycle it drains.
  assign bus.alu_ready = rst_n & (~alu_full_q | gnt[0]);
  assign bus.mem_ready = rst_n & (~mem_full_q | gnt[1]);
  assign alu_acc       = bus.alu_valid & bus.alu_ready;
  assign mem_acc       = bus.mem_valid & bus.mem_ready;

  always_comb begin
    alu_full_d = alu_full_q;
    alu_buf_d  = alu_buf_q;
    mem_full_d = mem_full_q;
    mem_buf_d  = mem_buf_q;
    if (gnt[0]) alu_full_d = 1'b0;
    if (gnt[1]) mem_full_d = 1'b0;
    if (alu_acc) begin
      alu_full_d     = 1'b1;
      alu_buf_d.addr = bus.alu_addr;
      alu_buf_d.data = bus.alu_data;
    end
    if (mem_acc) begin
      mem_full_d     = 1'b1;
      mem_buf_d.addr = bus.mem_addr;
      mem_buf_d.data = bus.mem_data;
    end
  end

  always_comb begin
    sel_addr = gnt[1] ? mem_buf_q.addr : alu_buf_q.addr;
    sel_data = gnt[1] ? mem_buf_q.data : alu_buf_q.data;
    we3_d    = |gnt;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    busy_d   = busy_q;
    err_d    = err_q;
    if (we3_d) begin
      wa3_d            = sel_addr;
      wd3_d            = sel_data;
      busy_d[sel_addr] = 1'b0;
      if (!busy_q[sel_addr]) err_d = 1'b1;
    end
    // Applied after the clear so a same-edge reservation keeps the bit set.
    if (bus.rsv_valid) busy_d[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_buf_q  <= '0;
      mem_buf_q  <= '0;
      alu_full_q <= 1'b0;
      mem_full_q <= 1'b0;
      busy_q     <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      alu_buf_q  <= alu_buf_d;
      mem_buf_q  <= mem_buf_d;
      alu_full_q <= alu_full_d;
      mem_full_q <= mem_full_d;
      busy_q     <= busy_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.err_unrsv = err_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Self-checking bench for vrf_write_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_vrf_write_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  vrf_write_arbiter_if #(.DATA_W(128), .ADDR_W(4), .DEPTH(16)) ifc ();

  vrf_write_arbiter #(.DATA_W(128), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: per-requester slot (index 0 = ALU, 1 = load unit).
  bit           m_full [2];
  logic [3:0]   m_addr [2];
  logic [127:0] m_data [2];
  int           m_prefer;
  logic [15:0]  m_busy;
  bit           m_err;
  bit           m_we;
  logic [3:0]   m_wa;
  logic [127:0] m_wd;
  bit           exp_rdy [2];
  bit           act_rdy [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_addr[k] = '0; m_data[k] = '0;
    end
    m_prefer = 0; m_busy = '0; m_err = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic idle_inputs();
    ifc.alu_valid = 0; ifc.alu_addr = '0; ifc.alu_data = '0;
    ifc.mem_valid = 0; ifc.mem_addr = '0; ifc.mem_data = '0;
    ifc.rsv_valid = 0; ifc.rsv_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Advance one clock: sample readies mid-cycle, step the model, return at posedge+1.
  task automatic tick();
    bit           v [2];
    logic [3:0]   a [2];
    logic [127:0] d [2];
    int           win;
    @(negedge clk);
    act_rdy[0] = ifc.alu_ready;
    act_rdy[1] = ifc.mem_ready;
    v[0] = ifc.alu_valid; a[0] = ifc.alu_addr; d[0] = ifc.alu_data;
    v[1] = ifc.mem_valid; a[1] = ifc.mem_addr; d[1] = ifc.mem_data;
    win = -1;
    if (m_full[0] && m_full[1]) begin
      win = m_prefer;
      m_prefer = 1 - m_prefer;
    end else if (m_full[0]) win = 0;
    else if (m_full[1]) win = 1;
    for (int k = 0; k < 2; k++) exp_rdy[k] = !m_full[k] || (win == k);
    m_we = (win >= 0);
    if (m_we) begin
      m_wa = m_addr[win];
      m_wd = m_data[win];
      if (!m_busy[m_wa]) m_err = 1;
      m_busy[m_wa] = 1'b0;
      m_full[win] = 0;
    end
    if (ifc.rsv_valid) m_busy[ifc.rsv_addr] = 1'b1;
    for (int k = 0; k < 2; k++)
      if (v[k] && exp_rdy[k]) begin
        m_full[k] = 1; m_addr[k] = a[k]; m_data[k] = d[k];
      end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_clear();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.we3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%0b exp=0", ifc.we3); end
    checks++; if (ifc.wa3 !== 4'h0) begin failures++; $display("FAIL reset_wa3 got=%0h exp=0", ifc.wa3); end
    checks++; if (ifc.wd3 !== 128'h0) begin failures++; $display("FAIL reset_wd3 got=%0h exp=0", ifc.wd3); end
    checks++; if (ifc.busy !== 16'h0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", ifc.busy); end
    checks++; if (ifc.err_unrsv !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", ifc.err_unrsv); end
    checks++; if (ifc.alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%0b exp=0", ifc.alu_ready); end
    checks++; if (ifc.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%0b exp=0", ifc.mem_ready); end
    rst_n = 1;
    tick();
    checks++; if (act_rdy[0] !== 1'b1) begin failures++; $display("FAIL release_alu_ready got=%0b exp=1", act_rdy[0]); end
    checks++; if (act_rdy[1] !== 1'b1) begin failures++; $display("FAIL release_mem_ready got=%0b exp=1", act_rdy[1]); end
  endtask

  task automatic test_single_write();
    logic [127:0] exp_d;
    exp_d = {32'd4, 32'd3, 32'd2, 32'd1};
    do_reset();
    ifc.rsv_valid = 1; ifc.rsv_addr = 4'd0;
    tick();
    ifc.rsv_valid = 0;
    checks++; if (ifc.busy[0] !== 1'b1) begin failures++; $display("FAIL single_busy_set got=%0b exp=1", ifc.busy[0]); end
    ifc.alu_valid = 1; ifc.alu_addr = 4'd0; ifc.alu_data = exp_d;
    tick();
    ifc.alu_valid = 0;
    checks++; if (ifc.we3 !== 1'b0) begin failures++; $display("FAIL single_we3_early got=%0b exp=0", ifc.we3); end
    tick();
    checks++; if (ifc.we3 !== 1'b1) begin failures++; $display("FAIL single_we3 got=%0b exp=1", ifc.we3); end
    checks++; if (ifc.wa3 !== 4'd0) begin failures++; $display("FAIL single_wa3 got=%0h exp=0", ifc.wa3); end
    checks++; if (ifc.wd3 !== exp_d) begin failures++; $display("FAIL single_wd3 got=%0h exp=%0h", ifc.wd3, exp_d); end
    checks++; if (ifc.busy[0] !== 1'b0) begin failures++; $display("FAIL single_busy_clr got=%0b exp=0", ifc.busy[0]); end
    checks++; if (ifc.err_unrsv !== 1'b0) begin failures++; $display("FAIL single_err got=%0b exp=0", ifc.err_unrsv); end
    tick();
    checks++; if (ifc.we3 !== 1'b0) begin failures++; $display("FAIL idle_we3 got=%0b exp=0", ifc.we3); end
    checks++; if (ifc.wa3 !== 4'd0 || ifc.wd3 !== exp_d) begin failures++; $display("FAIL idle_hold got=%0h/%0h exp=0/%0h", ifc.wa3, ifc.wd3, exp_d); end
  endtask

  task automatic test_collision();
    do_reset();
    ifc.alu_valid = 1; ifc.alu_addr = 4'd1; ifc.alu_data = {4{$urandom()}};
    ifc.mem_valid = 1; ifc.mem_addr = 4'd2; ifc.mem_data = {4{$urandom()}};
    tick();
    idle_inputs();
    tick();
    checks++; if (act_rdy[1] !== 1'b0) begin failures++; $display("FAIL coll_mem_ready got=%0b exp=0", act_rdy[1]); end
    checks++; if (ifc.we3 !== 1'b1 || ifc.wa3 !== 4'd1) begin failures++; $display("FAIL coll_first got=%0b/%0h exp=1/1", ifc.we3, ifc.wa3); end
    tick();
    checks++; if (ifc.we3 !== 1'b1 || ifc.wa3 !== 4'd2) begin failures++; $display("FAIL coll_second got=%0b/%0h exp=1/2", ifc.we3, ifc.wa3); end
    checks++; if (ifc.wd3 !== m_wd) begin failures++; $display("FAIL coll_wd3 got=%0h exp=%0h", ifc.wd3, m_wd); end
  endtask

  task automatic test_streaming();
    int writes = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ifc.alu_valid = 1; ifc.alu_addr = 4'(i);     ifc.alu_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      ifc.mem_valid = 1; ifc.mem_addr = 4'(8 + i); ifc.mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      if (ifc.we3 === 1'b1) writes++;
      checks++; if (act_rdy[0] !== exp_rdy[0] || act_rdy[1] !== exp_rdy[1]) begin failures++; $display("FAIL stream_ready[%0d] got=%0b%0b exp=%0b%0b", i, act_rdy[1], act_rdy[0], exp_rdy[1], exp_rdy[0]); end
      if (i > 0) begin
        checks++; if (ifc.we3 !== 1'b1 || ifc.wa3[3] !== 1'((i - 1) % 2)) begin failures++; $display("FAIL stream_alt[%0d] got=%0b/%0h exp=1/src%0d", i, ifc.we3, ifc.wa3, (i - 1) % 2); end
        checks++; if (ifc.wd3 !== m_wd) begin failures++; $display("FAIL stream_wd3[%0d] got=%0h exp=%0h", i, ifc.wd3, m_wd); end
      end
    end
    idle_inputs();
    tick();
    if (ifc.we3 === 1'b1) writes++;
    checks++; if (ifc.we3 !== 1'b1 || ifc.wa3[3] !== 1'b1) begin failures++; $display("FAIL stream_last got=%0b/%0h exp=1/src1", ifc.we3, ifc.wa3); end
    checks++; if (writes !== 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", writes); end
    repeat (3) begin
      tick();
      checks++; if (ifc.we3 !== m_we || ifc.wa3 !== m_wa) begin failures++; $display("FAIL stream_drain got=%0b/%0h exp=%0b/%0h", ifc.we3, ifc.wa3, m_we, m_wa); end
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    ifc.rsv_valid = 1; ifc.rsv_addr = 4'd5;
    tick();
    ifc.rsv_valid = 0;
    ifc.alu_valid = 1; ifc.alu_addr = 4'd5; ifc.alu_data = {4{$urandom()}};
    tick();
    ifc.alu_valid = 0;
    ifc.rsv_valid = 1; ifc.rsv_addr = 4'd5;
    tick();
    ifc.rsv_valid = 0;
    checks++; if (ifc.we3 !== 1'b1 || ifc.wa3 !== 4'd5) begin failures++; $display("FAIL same_write got=%0b/%0h exp=1/5", ifc.we3, ifc.wa3); end
    checks++; if (ifc.busy[5] !== 1'b1) begin failures++; $display("FAIL same_busy got=%0b exp=1", ifc.busy[5]); end
    checks++; if (ifc.err_unrsv !== 1'b0) begin failures++; $display("FAIL same_err got=%0b exp=0", ifc.err_unrsv); end
  endtask

  task automatic test_unreserved();
    do_reset();
    ifc.alu_valid = 1; ifc.alu_addr = 4'd7; ifc.alu_data = {4{$urandom()}};
    tick();
    ifc.alu_valid = 0;
    tick();
    checks++; if (ifc.we3 !== 1'b1 || ifc.wa3 !== 4'd7) begin failures++; $display("FAIL unrsv_write got=%0b/%0h exp=1/7", ifc.we3, ifc.wa3); end
    checks++; if (ifc.err_unrsv !== 1'b1) begin failures++; $display("FAIL unrsv_err got=%0b exp=1", ifc.err_unrsv); end
    repeat (5) tick();
    checks++; if (ifc.err_unrsv !== 1'b1) begin failures++; $display("FAIL unrsv_sticky got=%0b exp=1", ifc.err_unrsv); end
    do_reset();
    checks++; if (ifc.err_unrsv !== 1'b0) begin failures++; $display("FAIL unrsv_clear got=%0b exp=0", ifc.err_unrsv); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc.rsv_valid = 1; ifc.rsv_addr = 4'd3;
    tick();
    ifc.rsv_valid = 0;
    ifc.alu_valid = 1; ifc.alu_addr = 4'd3; ifc.alu_data = {4{$urandom()}};
    ifc.mem_valid = 1; ifc.mem_addr = 4'd4; ifc.mem_data = {4{$urandom()}};
    tick();
    tick();
    checks++; if (ifc.we3 !== 1'b1) begin failures++; $display("FAIL mid_pre_we3 got=%0b exp=1", ifc.we3); end
    rst_n = 0;
    idle_inputs();
    model_clear();
    #1;
    checks++; if (ifc.we3 !== 1'b0) begin failures++; $display("FAIL mid_we3 got=%0b exp=0", ifc.we3); end
    checks++; if (ifc.busy !== 16'h0) begin failures++; $display("FAIL mid_busy got=%0h exp=0", ifc.busy); end
    checks++; if (ifc.alu_ready !== 1'b0 || ifc.mem_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b%0b exp=00", ifc.mem_ready, ifc.alu_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (ifc.we3 !== 1'b0) begin failures++; $display("FAIL mid_replay[%0d] got=%0b exp=0", i, ifc.we3); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ifc.alu_valid = ($urandom_range(0, 9) < 7);
      ifc.alu_addr  = 4'($urandom_range(0, 15));
      ifc.alu_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ifc.mem_valid = ($urandom_range(0, 9) < 6);
      ifc.mem_addr  = 4'($urandom_range(0, 15));
      ifc.mem_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ifc.rsv_valid = ($urandom_range(0, 9) < 8);
      ifc.rsv_addr  = 4'($urandom_range(0, 15));
      tick();
      checks++; if (act_rdy[0] !== exp_rdy[0] || act_rdy[1] !== exp_rdy[1]) begin failures++; $display("FAIL rand_ready[%0d] got=%0b%0b exp=%0b%0b", i, act_rdy[1], act_rdy[0], exp_rdy[1], exp_rdy[0]); end
      checks++; if (ifc.we3 !== m_we || ifc.wa3 !== m_wa) begin failures++; $display("FAIL rand_we_wa[%0d] got=%0b/%0h exp=%0b/%0h", i, ifc.we3, ifc.wa3, m_we, m_wa); end
      checks++; if (ifc.wd3 !== m_wd) begin failures++; $display("FAIL rand_wd3[%0d] got=%0h exp=%0h", i, ifc.wd3, m_wd); end
      checks++; if (ifc.busy !== m_busy) begin failures++; $display("FAIL rand_busy[%0d] got=%0h exp=%0h", i, ifc.busy, m_busy); end
      checks++; if (ifc.err_unrsv !== m_err) begin failures++; $display("FAIL rand_err[%0d] got=%0b exp=%0b", i, ifc.err_unrsv, m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_collision();
    test_streaming();
    test_same_edge();
    test_unreserved();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vrf_write_arbiter.md
VRF_WRITE_ARBITER -- requirements
Module: vrf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 128, vector register width (4 lanes x 32 bit).
REQ-002 SHALL have parameter ADDR_W, 4, register address width (16 vector registers).
REQ-003 SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports alu_valid in 1, alu_ready out 1, alu_addr in ADDR_W, alu_data in DATA_W: ALU writeback requester (req 0).
REQ-007 SHALL have ports mem_valid in 1, mem_ready out 1, mem_addr in ADDR_W, mem_data in DATA_W: load-unit writeback requester (req 1).
REQ-008 SHALL have ports rsv_valid in 1, rsv_addr in ADDR_W: issue stage reserves a destination register.
REQ-009 SHALL have port busy  out  16  per-register pending-write scoreboard.
REQ-010 SHALL have ports we3 out 1, wa3 out ADDR_W, wd3 out DATA_W: registered drive of the register-file write port.
REQ-011 SHALL have port err_unrsv  out  1  sticky flag: a write retired to a non-busy register.

Function
REQ-012 Each requester SHALL own a 1-entry holding buffer; transfer occurs at a rising edge with valid & ready.
REQ-013 x_ready SHALL be high when its buffer is empty or its buffer is granted in the current cycle (same-cycle refill).
REQ-014 Arbitration SHALL be combinational over full buffers; only one full buffer -> it wins; both full -> round-robin.
REQ-015 Round-robin pointer SHALL flip to the other requester after every grant made while both buffers were full; after reset req 0 (ALU) has priority.
REQ-016 Granted entry SHALL load we3=1, wa3, wd3 at the next edge; minimum latency acceptance-edge to we3 high is 1 cycle.
REQ-017 No full buffer SHALL load we3=0; wa3/wd3 SHALL hold their previous values.
REQ-018 Sustained throughput SHALL be one write per cycle; with both requesters streaming each SHALL get every other cycle.
REQ-019 rsv_valid SHALL set busy[rsv_addr] at the edge.
REQ-020 Loading we3=1 for address a SHALL clear busy[a] at the same edge.
REQ-021 Set and clear of the same address in one edge: set SHALL win (busy stays 1).
REQ-022 A write retired to an address with busy=0 SHALL still be issued and SHALL set err_unrsv, held until reset.
REQ-023 Two buffers holding the same address SHALL be resolved by round-robin only; WAW ordering is guaranteed by issue, not by this block.
REQ-024 Requester data SHALL be passed unmodified; no width conversion.

Reset
REQ-025 rst_n low SHALL immediately clear both buffers, busy=16'h0, we3=0, wa3=0, wd3=0, err_unrsv=0, pointer=req 0.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight writes; nothing is replayed after release.
REQ-027 During reset alu_ready and mem_ready SHALL be 0; they SHALL rise in the first cycle after release.

Structure
REQ-028 Shared package vrf_pkg SHALL hold VRF_DEPTH=16, DATA_W=128, ADDR_W=4 and typedef vrf_wr_t {addr, data}.
REQ-029 Round-robin selection SHALL live in sub-module rr_arbiter2 (2 requests, pointer state, one-hot grant).
REQ-030 Buffers, scoreboard and output registers SHALL stay in the top module.

Verification
REQ-031 Single write: rsv 0; alu write addr 0, data {4,3,2,1} -> next cycle we3=1, wa3=0, wd3 lanes 1/2/3/4; busy[0] 1->0.
REQ-032 Collision: alu (addr 1) and mem (addr 2) valid same edge -> addr 1 written first, addr 2 the following cycle, mem_ready low in between.
REQ-033 Streaming: both valid for 8 cycles -> writes alternate alu/mem, 8 writes in 8 cycles after first latency.
REQ-034 Same-edge set/clear: busy[5]=1, write addr 5 retires while rsv_addr=5 -> busy[5] stays 1.
REQ-035 Unreserved write to addr 7 with busy=0 -> write issued, err_unrsv=1 until reset.
REQ-036 rst_n low while both buffers full -> we3=0, busy=0 immediately; no write appears after release.
